// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_pkg
// Purpose  : Shared definitions for the unified-memory arbiter. This package
//            holds the FSM state encodings and the read data returned when a
//            command times out.
// Revision : 1.0  initial release
// ============================================================================
package mem_bus_arbiter_pkg;

  // Arbiter FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    ARB_ST_IDLE    = 2'd0,
    ARB_ST_IF_BUSY = 2'd1,
    ARB_ST_LS_BUSY = 2'd2,
    ARB_ST_RESP    = 2'd3
  } arb_state_t;

  // Read data returned to the owner when a command is abandoned by timeout
  localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'h0000_0000;

  // Width of the watchdog cycle counter
  localparam int ARB_WDOG_W = 8;

endpackage : mem_bus_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_watchdog
// Purpose  : Counts BUSY cycles without a memory ack. When the count reaches
//            TIMEOUT_CYCLES it raises a single-cycle timeout and sets a sticky
//            error flag. The flag is cleared only by reset.
// Revision : 1.0  initial release
// Ports    : clk_i, rst_i   - clock / async active-high reset
//            start_i        - BUSY entry; clears the counter
//            busy_i         - a command is outstanding
//            ack_i          - memory ack (overrides a coincident timeout)
//            timeout_o      - combinational timeout strobe (BUSY cycle)
//            err_o          - registered sticky timeout flag
// ============================================================================
module mem_arb_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic busy_i,
  input  logic ack_i,
  output logic timeout_o,
  output logic err_o
);

  // Fire on the last BUSY cycle of the allowed window, so TIMEOUT_CYCLES
  // BUSY cycles have elapsed when the arbiter leaves BUSY.
  localparam logic [ARB_WDOG_W-1:0] C_LIMIT = ARB_WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [ARB_WDOG_W-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;

  assign timeout_o = busy_i & ~ack_i & (cnt_q == C_LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | timeout_o;
    if (start_i) begin
      cnt_d = '0;
    end else if (busy_i && !ack_i && (cnt_q != {ARB_WDOG_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule : mem_arb_watchdog
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one memory port between the instruction-fetch (IF) and
//            load/store (LS) requesters. The arbiter serves one command at a
//            time and holds it until MEM_ACK. It then gives a one-cycle grant
//            and asserts HALT while any request is still unserved.
// Revision : 1.0  initial release
// Config   : MEM_ARB_TIMEOUT_EN - when defined, adds the mem_arb_watchdog.
//            A stalled command then completes after TIMEOUT_CYCLES with zero
//            read data and sets the sticky TIMEOUT_ERR flag.
// Ports    : CK_REF/RST           - clock / async active-high reset
//            IF_REQ/ADDR/GNT/RDATA - fetch side (read only)
//            LS_REQ/READ_WRN/ADDR/WDATA/GNT/RDATA - load/store side
//            MEM_REQ/READ_WRN/ADDR/WDATA/ACK/RDATA - memory port
//            HALT                 - combinational pipeline freeze
//            TIMEOUT_ERR          - sticky memory-timeout flag
// ============================================================================
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CK_REF,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_GNT,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              LS_REQ,
  input  logic              LS_READ_WRN,
  input  logic [ADDR_W-1:0] LS_ADDR,
  input  logic [DATA_W-1:0] LS_WDATA,
  output logic              LS_GNT,
  output logic [DATA_W-1:0] LS_RDATA,
  output logic              MEM_REQ,
  output logic              MEM_READ_WRN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              HALT,
  output logic              TIMEOUT_ERR
);

  arb_state_t        state_q, state_d;
  logic              last_ls_q, last_ls_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_read_wrn_q, mem_read_wrn_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              if_gnt_q, if_gnt_d;
  logic              ls_gnt_q, ls_gnt_d;

  logic              w_busy;
  logic              w_wdog_start;
  logic              w_timeout;
  logic              w_done;
  logic [DATA_W-1:0] w_rd_data;

  assign w_busy = (state_q == ARB_ST_IF_BUSY) || (state_q == ARB_ST_LS_BUSY);

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (CK_REF),
    .rst_i     (RST),
    .start_i   (w_wdog_start),
    .busy_i    (w_busy),
    .ack_i     (MEM_ACK),
    .timeout_o (w_timeout),
    .err_o     (TIMEOUT_ERR)
  );
`else
  // Without the watchdog, a BUSY state waits for MEM_ACK indefinitely.
  logic w_unused_wdog;
  assign w_unused_wdog = ^{w_wdog_start, w_busy, 32'(TIMEOUT_CYCLES)};
  assign w_timeout     = 1'b0;
  assign TIMEOUT_ERR   = 1'b0;
`endif

  // An ack wins over a coincident timeout and completes the command normally.
  assign w_done    = MEM_ACK | w_timeout;
  assign w_rd_data = MEM_ACK ? MEM_RDATA : DATA_W'(ARB_TIMEOUT_RDATA);

  always_comb begin
    state_d        = state_q;
    last_ls_d      = last_ls_q;
    mem_req_d      = mem_req_q;
    mem_read_wrn_d = mem_read_wrn_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    if_rdata_d     = if_rdata_q;
    ls_rdata_d     = ls_rdata_q;
    if_gnt_d       = 1'b0;
    ls_gnt_d       = 1'b0;
    w_wdog_start   = 1'b0;

    case (state_q)
      ARB_ST_IDLE: begin
        // LS has priority unless it won last time and IF is also waiting.
        if (LS_REQ && (!IF_REQ || !last_ls_q)) begin
          state_d        = ARB_ST_LS_BUSY;
          mem_req_d      = 1'b1;
          mem_read_wrn_d = LS_READ_WRN;
          mem_addr_d     = LS_ADDR;
          mem_wdata_d    = LS_WDATA;
          w_wdog_start   = 1'b1;
        end else if (IF_REQ) begin
          state_d        = ARB_ST_IF_BUSY;
          mem_req_d      = 1'b1;
          mem_read_wrn_d = 1'b1;
          mem_addr_d     = IF_ADDR;
          w_wdog_start   = 1'b1;
        end
      end

      ARB_ST_IF_BUSY: begin
        if (w_done) begin
          state_d    = ARB_ST_RESP;
          mem_req_d  = 1'b0;
          if_rdata_d = w_rd_data;
          if_gnt_d   = 1'b1;
          last_ls_d  = 1'b0;
        end
      end

      ARB_ST_LS_BUSY: begin
        if (w_done) begin
          state_d   = ARB_ST_RESP;
          mem_req_d = 1'b0;
          if (mem_read_wrn_q) begin
            ls_rdata_d = w_rd_data;
          end
          ls_gnt_d  = 1'b1;
          last_ls_d = 1'b1;
        end
      end

      // The grant is visible during this cycle. Skipping arbitration here
      // keeps the just-served request from being taken a second time.
      ARB_ST_RESP: begin
        state_d = ARB_ST_IDLE;
      end

      default: begin
        state_d = ARB_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK_REF or posedge RST) begin
    if (RST) begin
      state_q        <= ARB_ST_IDLE;
      last_ls_q      <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_read_wrn_q <= 1'b1;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      if_rdata_q     <= '0;
      ls_rdata_q     <= '0;
      if_gnt_q       <= 1'b0;
      ls_gnt_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_ls_q      <= last_ls_d;
      mem_req_q      <= mem_req_d;
      mem_read_wrn_q <= mem_read_wrn_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      if_rdata_q     <= if_rdata_d;
      ls_rdata_q     <= ls_rdata_d;
      if_gnt_q       <= if_gnt_d;
      ls_gnt_q       <= ls_gnt_d;
    end
  end

  assign MEM_REQ      = mem_req_q;
  assign MEM_READ_WRN = mem_read_wrn_q;
  assign MEM_ADDR     = mem_addr_q;
  assign MEM_WDATA    = mem_wdata_q;
  assign IF_RDATA     = if_rdata_q;
  assign LS_RDATA     = ls_rdata_q;
  assign IF_GNT       = if_gnt_q;
  assign LS_GNT       = ls_gnt_q;

  // Uses only inputs and registered grants, so there is no path from MEM_ACK.
  assign HALT = (IF_REQ & ~if_gnt_q) | (LS_REQ & ~ls_gnt_q);

endmodule : mem_bus_arbiter
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed self-checking bench for mem_bus_arbiter. Inputs change
//            on the falling clock edge. Outputs are sampled 1 ns later, away
//            from the rising (active) edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        CK_REF = 1'b0;
  logic        RST;
  logic        IF_REQ, LS_REQ, LS_READ_WRN, MEM_ACK;
  logic [15:0] IF_ADDR, LS_ADDR;
  logic [31:0] LS_WDATA, MEM_RDATA;
  logic        IF_GNT, LS_GNT, MEM_REQ, MEM_READ_WRN, HALT, TIMEOUT_ERR;
  logic [31:0] IF_RDATA, LS_RDATA, MEM_WDATA;
  logic [15:0] MEM_ADDR;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(
    .ADDR_W         (16),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .CK_REF       (CK_REF),
    .RST          (RST),
    .IF_REQ       (IF_REQ),
    .IF_ADDR      (IF_ADDR),
    .IF_GNT       (IF_GNT),
    .IF_RDATA     (IF_RDATA),
    .LS_REQ       (LS_REQ),
    .LS_READ_WRN  (LS_READ_WRN),
    .LS_ADDR      (LS_ADDR),
    .LS_WDATA     (LS_WDATA),
    .LS_GNT       (LS_GNT),
    .LS_RDATA     (LS_RDATA),
    .MEM_REQ      (MEM_REQ),
    .MEM_READ_WRN (MEM_READ_WRN),
    .MEM_ADDR     (MEM_ADDR),
    .MEM_WDATA    (MEM_WDATA),
    .MEM_ACK      (MEM_ACK),
    .MEM_RDATA    (MEM_RDATA),
    .HALT         (HALT),
    .TIMEOUT_ERR  (TIMEOUT_ERR)
  );

  always #5 CK_REF = ~CK_REF;

  // Control vector: {MEM_REQ, MEM_READ_WRN, IF_GNT, LS_GNT, HALT, TIMEOUT_ERR}
  function automatic logic [5:0] ctl();
    return {MEM_REQ, MEM_READ_WRN, IF_GNT, LS_GNT, HALT, TIMEOUT_ERR};
  endfunction

  task automatic test_reset();
    RST = 1'b1; IF_REQ = 0; LS_REQ = 0; LS_READ_WRN = 1; MEM_ACK = 0;
    IF_ADDR = '0; LS_ADDR = '0; LS_WDATA = '0; MEM_RDATA = '0;
    repeat (2) @(negedge CK_REF);
    #1;
    checks++;
    if (ctl() !== 6'b010000) begin
      errors++; $display("FAIL reset_ctl got %b exp %b", ctl(), 6'b010000);
    end
    checks++;
    if ({MEM_ADDR, MEM_WDATA, IF_RDATA, LS_RDATA} !== 112'd0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {MEM_ADDR, MEM_WDATA, IF_RDATA, LS_RDATA});
    end
    @(negedge CK_REF); RST = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge CK_REF); IF_REQ = 1; IF_ADDR = 16'h0010; #1;           // cycle 0
    checks++;
    if (ctl() !== 6'b010010) begin errors++; $display("FAIL fetch_c0 got %b exp %b", ctl(), 6'b010010); end
    @(negedge CK_REF); #1;                                            // cycle 1
    checks++;
    if ({ctl(), MEM_ADDR} !== {6'b110010, 16'h0010}) begin
      errors++; $display("FAIL fetch_c1 got %b/%h exp 110010/0010", ctl(), MEM_ADDR);
    end
    @(negedge CK_REF); MEM_ACK = 1; MEM_RDATA = 32'h0000_0013; #1;   // cycle 2
    checks++;
    if (ctl() !== 6'b110010) begin errors++; $display("FAIL fetch_c2 got %b exp %b", ctl(), 6'b110010); end
    @(negedge CK_REF); MEM_ACK = 0; MEM_RDATA = 32'hFFFF_FFFF; #1;   // cycle 3
    checks++;
    if ({ctl(), IF_RDATA} !== {6'b011000, 32'h0000_0013}) begin
      errors++; $display("FAIL fetch_gnt got %b/%h exp 011000/00000013", ctl(), IF_RDATA);
    end
    @(negedge CK_REF); IF_REQ = 0; #1;                                // cycle 4
    checks++;
    if (ctl() !== 6'b010000) begin errors++; $display("FAIL fetch_c4 got %b exp %b", ctl(), 6'b010000); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt;
    for (int c = 0; c < 12; c++) begin
      @(negedge CK_REF);
      if (c == 0) begin
        IF_REQ = 1; IF_ADDR = 16'h0020;
        LS_REQ = 1; LS_READ_WRN = 1; LS_ADDR = 16'h0030;
      end
      MEM_ACK   = MEM_REQ;                       // responder acks at once
      MEM_RDATA = 32'hA000_0000 | {16'h0, MEM_ADDR};
      #1;
      exp_gnt = (c == 5 || c == 11) ? 2'b10 : (c == 2 || c == 8) ? 2'b01 : 2'b00;
      checks++;
      if ({IF_GNT, LS_GNT} !== exp_gnt) begin
        errors++; $display("FAIL contend_gnt c%0d got %b exp %b", c, {IF_GNT, LS_GNT}, exp_gnt);
      end
      if (c == 1 || c == 4) begin
        checks++;
        if (MEM_ADDR !== ((c == 1) ? 16'h0030 : 16'h0020)) begin
          errors++; $display("FAIL contend_addr c%0d got %h", c, MEM_ADDR);
        end
      end
      if (c == 11) begin
        checks++;
        if ({IF_RDATA, LS_RDATA} !== {32'hA000_0020, 32'hA000_0030}) begin
          errors++; $display("FAIL contend_rdata got %h/%h exp a0000020/a0000030", IF_RDATA, LS_RDATA);
        end
      end
    end
    @(negedge CK_REF); IF_REQ = 0; LS_REQ = 0; MEM_ACK = 0; #1;
    checks++;
    if (ctl() !== 6'b010000) begin errors++; $display("FAIL contend_end got %b exp %b", ctl(), 6'b010000); end
  endtask

  task automatic test_load();
    @(negedge CK_REF); LS_REQ = 1; LS_READ_WRN = 1; LS_ADDR = 16'h0200; #1;
    @(negedge CK_REF); MEM_ACK = 1; MEM_RDATA = 32'h1234_5678; #1;
    checks++;
    if ({ctl(), MEM_ADDR} !== {6'b110010, 16'h0200}) begin
      errors++; $display("FAIL load_cmd got %b/%h exp 110010/0200", ctl(), MEM_ADDR);
    end
    @(negedge CK_REF); MEM_ACK = 0; #1;
    checks++;
    if ({ctl(), LS_RDATA} !== {6'b010100, 32'h1234_5678}) begin
      errors++; $display("FAIL load_gnt got %b/%h exp 010100/12345678", ctl(), LS_RDATA);
    end
    @(negedge CK_REF); LS_REQ = 0;
  endtask

  task automatic test_store();
    @(negedge CK_REF);
    LS_REQ = 1; LS_READ_WRN = 0; LS_ADDR = 16'h0100; LS_WDATA = 32'hCAFE_F00D;
    MEM_RDATA = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CK_REF); MEM_ACK = (c == 4); #1;
      checks++;
      if ({ctl(), MEM_ADDR, MEM_WDATA} !== {6'b100010, 16'h0100, 32'hCAFE_F00D}) begin
        errors++; $display("FAIL store_hold c%0d got %b/%h/%h", c, ctl(), MEM_ADDR, MEM_WDATA);
      end
    end
    @(negedge CK_REF); MEM_ACK = 0; #1;
    checks++;
    if ({ctl(), LS_RDATA} !== {6'b000100, 32'h1234_5678}) begin
      errors++; $display("FAIL store_gnt got %b/%h exp 000100/12345678", ctl(), LS_RDATA);
    end
    @(negedge CK_REF); LS_REQ = 0; LS_READ_WRN = 1; #1;
    checks++;
    if (LS_GNT !== 1'b0) begin errors++; $display("FAIL store_gnt_len got %b exp 0", LS_GNT); end
  endtask

  task automatic test_stray_ack();
    for (int c = 0; c < 3; c++) begin
      @(negedge CK_REF); MEM_ACK = 1; MEM_RDATA = 32'h5555_AAAA; #1;
    end
    @(negedge CK_REF); MEM_ACK = 0; #1;
    checks++;
    if ({ctl(), IF_RDATA, LS_RDATA} !== {6'b000000, 32'hA000_0020, 32'h1234_5678}) begin
      errors++; $display("FAIL stray_ack got %b/%h/%h", ctl(), IF_RDATA, LS_RDATA);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CK_REF);
    LS_REQ = 1; LS_READ_WRN = 0; LS_ADDR = 16'h0300; LS_WDATA = 32'h0000_0055;
    @(negedge CK_REF); #1;
    checks++;
    if (MEM_REQ !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b exp 1", MEM_REQ); end
    #2; RST = 1'b1; #1;                        // asynchronous: no clock edge yet
    checks++;
    if ({ctl(), MEM_ADDR, MEM_WDATA, IF_RDATA, LS_RDATA} !== {6'b010010, 112'd0}) begin
      errors++; $display("FAIL rstmid_async got %b/%h/%h/%h/%h", ctl(), MEM_ADDR, MEM_WDATA, IF_RDATA, LS_RDATA);
    end
    LS_REQ = 0; LS_READ_WRN = 1;
    @(negedge CK_REF); RST = 1'b0;
    repeat (3) begin
      @(negedge CK_REF); #1;
      checks++;
      if (ctl() !== 6'b010000) begin errors++; $display("FAIL rstmid_nognt got %b exp %b", ctl(), 6'b010000); end
    end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    // successful fetch first so IF_RDATA is non-zero before the timeout
    @(negedge CK_REF); IF_REQ = 1; IF_ADDR = 16'h0050;
    @(negedge CK_REF); MEM_ACK = 1; MEM_RDATA = 32'h0000_0077;
    @(negedge CK_REF); MEM_ACK = 0; #1;
    checks++;
    if ({IF_GNT, IF_RDATA, TIMEOUT_ERR} !== {1'b1, 32'h0000_0077, 1'b0}) begin
      errors++; $display("FAIL tmo_pre got %b/%h/%b", IF_GNT, IF_RDATA, TIMEOUT_ERR);
    end
    @(negedge CK_REF); IF_ADDR = 16'h0060;     // new request on the grant edge
    for (int c = 1; c <= 4; c++) begin
      @(negedge CK_REF); #1;
      checks++;
      if (ctl() !== 6'b110010) begin errors++; $display("FAIL tmo_busy c%0d got %b exp %b", c, ctl(), 6'b110010); end
    end
    @(negedge CK_REF); #1;
    checks++;
    if ({ctl(), IF_RDATA} !== {6'b011001, 32'h0}) begin
      errors++; $display("FAIL tmo_gnt got %b/%h exp 011001/00000000", ctl(), IF_RDATA);
    end
    @(negedge CK_REF); IF_ADDR = 16'h0070;
    @(negedge CK_REF); MEM_ACK = 1; MEM_RDATA = 32'h0000_0099;
    @(negedge CK_REF); MEM_ACK = 0; #1;
    checks++;
    if ({IF_GNT, IF_RDATA, TIMEOUT_ERR} !== {1'b1, 32'h0000_0099, 1'b1}) begin
      errors++; $display("FAIL tmo_sticky got %b/%h/%b", IF_GNT, IF_RDATA, TIMEOUT_ERR);
    end
    @(negedge CK_REF); IF_REQ = 0;
  endtask
`else
  task automatic test_timeout();
    @(negedge CK_REF); IF_REQ = 1; IF_ADDR = 16'h0060;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CK_REF); #1;
      checks++;
      if (ctl() !== 6'b110010) begin errors++; $display("FAIL notmo_wait c%0d got %b exp %b", c, ctl(), 6'b110010); end
    end
    @(negedge CK_REF); MEM_ACK = 1; MEM_RDATA = 32'h0000_00AB;
    @(negedge CK_REF); MEM_ACK = 0; #1;
    checks++;
    if ({ctl(), IF_RDATA} !== {6'b011000, 32'h0000_00AB}) begin
      errors++; $display("FAIL notmo_gnt got %b/%h exp 011000/000000ab", ctl(), IF_RDATA);
    end
    @(negedge CK_REF); IF_REQ = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_load();
    test_store();
    test_stray_ack();
    test_reset_mid();
    test_timeout();
    repeat (2) @(negedge CK_REF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_bus_arbiter
`default_nettype wire
